// File: rtl/sseg_scan.sv
// sseg_scan -- eight-digit multiplexed seven-segment display driver.
//
// Scans eight hex digits one at a time, each lit for SCAN_DIV clock cycles.
// The displayed value and decimal points are captured into shadow registers
// once per frame, at the end of digit 7, so a frame never mixes old and new
// data.
//
// Parameters:
//   SCAN_DIV  clock cycles each digit stays lit (2 .. 2**20)
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous, active-high reset
//   data     32-bit hex value; nibble k drives digit k (digit 0 rightmost)
//   dp       decimal-point request; bit k lights the point of digit k
//   SSEG_CA  cathodes, active low, {dp,g,f,e,d,c,b,a}, registered
//   SSEG_AN  anodes, active low, bit k selects digit k, registered
// Build options:
//   SSEG_BLANK_EN  when defined, leading-zero digits (k >= 1) are blanked

module sseg_scan #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [7:0]  dp,
  output logic [7:0]  SSEG_CA,
  output logic [7:0]  SSEG_AN
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [31:0]      sh_data;
  logic [7:0]       sh_dp;

  logic             tick;
  logic [3:0]       nib;
  logic [6:0]       seg;
  logic             blank;
  logic [7:0]       an_nxt;
  logic [7:0]       ca_nxt;

  always_comb begin
    tick = (cnt == CNT_LAST);
    nib  = sh_data[{idx, 2'b00} +: 4];

    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase

    blank = 1'b0;
`ifdef SSEG_BLANK_EN
    // A digit is a leading zero when it and every more significant nibble
    // are zero; the dp request is deliberately ignored here.
    blank = (idx != 3'd0) && ((sh_data >> {idx, 2'b00}) == 32'd0);
`endif

    an_nxt = ~(8'b1 << idx);
    ca_nxt = {~sh_dp[idx], seg};
    if (blank) begin
      an_nxt = '1;
      ca_nxt = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= '0;
      sh_data <= '0;
      sh_dp   <= '0;
      SSEG_AN <= '1;
      SSEG_CA <= '1;
    end else begin
      SSEG_AN <= an_nxt;
      SSEG_CA <= ca_nxt;
      if (tick) begin
        cnt <= '0;
        idx <= idx + 3'd1;
        // Frame boundary: capture new display content as idx wraps to 0.
        if (idx == 3'd7) begin
          sh_data <= data;
          sh_dp   <= dp;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan.sv
module tb_sseg_scan;

  localparam int unsigned SD    = 4;
  localparam int unsigned FRAME = 8 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = '0;
  logic [7:0]  dp = '0;
  logic [7:0]  sseg_ca;
  logic [7:0]  sseg_an;

  sseg_scan #(.SCAN_DIV(SD)) dut (
    .clk     (clk),
    .rst     (rst),
    .data    (data),
    .dp      (dp),
    .SSEG_CA (sseg_ca),
    .SSEG_AN (sseg_an)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [7:0] f1 [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
  logic [7:0] f4 [8] = '{8'h92, 8'hC0, 8'h88, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};

  // Reference model: cycles since reset release determine the digit slot and
  // the frame; each frame shows the inputs present at the last edge of the
  // previous frame (zeros in the first frame after reset).
  int unsigned m_e = 0;
  int unsigned m_d;
  logic [3:0]  m_nib;
  logic [31:0] m_data = '0;
  logic [7:0]  m_dp = '0;
  logic [7:0]  exp_an, exp_ca;
  bit          exp_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_e    = 0;
      m_data = '0;
      m_dp   = '0;
      exp_an = 8'hFF;
      exp_ca = 8'hFF;
    end else begin
      m_d    = (m_e / SD) % 8;
      m_nib  = 4'((m_data >> (4 * m_d)) & 32'hF);
      exp_an = 8'hFF;
      exp_an[m_d] = 1'b0;
      exp_ca = {~m_dp[m_d], seg_tab[m_nib][6:0]};
`ifdef SSEG_BLANK_EN
      if (m_d != 0 && (m_data >> (4 * m_d)) == 32'd0) begin
        exp_an = 8'hFF;
        exp_ca = 8'hFF;
      end
`endif
      if (m_e % FRAME == FRAME - 1) begin
        m_data = data;
        m_dp   = dp;
      end
      m_e = m_e + 1;
    end
    exp_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (exp_valid) begin
      n_checks++;
      if (sseg_an === exp_an && sseg_ca === exp_ca)
        n_pass++;
      else
        $display("FAIL model t=%0t AN=%h CA=%h required AN=%h CA=%h",
                 $time, sseg_an, sseg_ca, exp_an, exp_ca);
    end
  end

  task automatic lit(input string name, input logic [7:0] an, input logic [7:0] ca);
    n_checks++;
    if (sseg_an === an && sseg_ca === ca)
      n_pass++;
    else
      $display("FAIL %s t=%0t AN=%h CA=%h required AN=%h CA=%h",
               name, $time, sseg_an, sseg_ca, an, ca);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    lit("reset", 8'hFF, 8'hFF);
    rst  = 1'b0;
    data = 32'h12345678;
    dp   = 8'h00;

    for (int unsigned e = 0; e <= 182; e++) begin
      int unsigned k;
      logic [7:0]  a;
      @(posedge clk);
      #1;
      k = (e / SD) % 8;
      a = 8'hFF;
      a[k] = 1'b0;

      if (e == 0) lit("release", 8'hFE, 8'hC0);
      if (e >= 32 && e < 64) lit("frame_12345678", a, f1[k]);
      if (e >= 64 && e < 96 && e % SD == 0) lit("frame_ffffffff", a, 8'h8E);
      if (e >= 96 && e < 128 && e % SD == 2) begin
`ifdef SSEG_BLANK_EN
        if (k == 0) lit("frame_zero_dp", a, 8'hC0);
        else        lit("frame_zero_dp", 8'hFF, 8'hFF);
`else
        lit("frame_zero_dp", a, (k == 2) ? 8'h40 : 8'hC0);
`endif
      end
      if (e >= 128 && e < 160 && e % SD == 1) begin
`ifdef SSEG_BLANK_EN
        if (k <= 2) lit("frame_a05", a, f4[k]);
        else        lit("frame_a05", 8'hFF, 8'hFF);
`else
        lit("frame_a05", a, f4[k]);
`endif
      end
      if (e == 182) lit("rst_mid_digit5", 8'hFF, 8'hFF);

      if (e == 40) data = 32'hFFFFFFFF;
      if (e == 70) begin data = 32'h0; dp = 8'h04; end
      if (e == 100) begin data = 32'h00000A05; dp = 8'h00; end
      if (e == 181) rst = 1'b1;
      if (e == 182) rst = 1'b0;
    end

    @(posedge clk);
    #1;
    lit("rst_resume", 8'hFE, 8'hC0);
    repeat (9) @(posedge clk);
    #1;
`ifdef SSEG_BLANK_EN
    lit("rst_cleared_shadow", 8'hFF, 8'hFF);
`else
    lit("rst_cleared_shadow", 8'hFB, 8'hC0);
`endif

    for (int unsigned i = 0; i < 1200; i++) begin
      @(posedge clk);
      #1;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      if ($urandom_range(0, 11) == 0) begin
        data = $urandom >> (4 * $urandom_range(0, 7));
        dp   = 8'($urandom);
      end
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sseg_scan.md
SSEG_SCAN -- requirements
Module: sseg_scan

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clock cycles each digit stays lit; legal range 2..2^20.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 data  input  32  hex value to display; nibble k drives digit k, digit 0 rightmost.
REQ-005 dp  input  8  decimal-point request; bit k lights the point of digit k.
REQ-006 SSEG_CA  output  8  cathodes, active low, bit order {dp,g,f,e,d,c,b,a}; registered.
REQ-007 SSEG_AN  output  8  anodes, active low, bit k selects digit k; registered.

Function
REQ-008 Divider cnt increments every cycle; at cnt==SCAN_DIV-1 it asserts an internal tick and returns to 0.
REQ-009 Digit index idx (0..7) increments on tick; wraps 7->0.
REQ-010 Shadow registers sh_data/sh_dp load data/dp on a tick with idx==7, on the same edge idx wraps to 0.
REQ-011 data/dp changes mid-frame are not displayed until the next frame; frame length is 8*SCAN_DIV cycles.
REQ-012 Each non-reset cycle: SSEG_AN <= ~(1<<idx); SSEG_CA[6:0] <= decode(sh_data nibble idx); SSEG_CA[7] <= ~sh_dp[idx].
REQ-013 Outputs lag idx by one cycle; each digit is driven for exactly SCAN_DIV consecutive cycles.
REQ-014 Decode, hex 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E (7-bit value in SSEG_CA[6:0], dp bit 1).
REQ-015 Exactly one SSEG_AN bit is low in every non-reset cycle except where REQ-020 blanks a digit.

Reset
REQ-016 rst high: cnt=0, idx=0, sh_data=0, sh_dp=0, SSEG_AN=8'hFF, SSEG_CA=8'hFF.
REQ-017 First edge after rst falls: SSEG_AN=8'hFE, SSEG_CA=8'hC0 (digit 0 shows 0 from cleared shadow).
REQ-018 rst asserted mid-digit or mid-frame overrides the tick and the shadow load on that edge; the scan restarts at digit 0 with cnt=0.

Configuration
REQ-019 Macro SSEG_BLANK_EN selects leading-zero blanking.
REQ-020 With SSEG_BLANK_EN: digit k>=1 is blanked (SSEG_AN=8'hFF, SSEG_CA=8'hFF for its slot) when sh_data nibbles k..7 are all zero; digit 0 is never blanked; the dp request does not prevent blanking.
REQ-021 Without SSEG_BLANK_EN: all eight digits are always driven and zeros display as C0.

Verification (SCAN_DIV=4)
REQ-022 Hold rst 2 cycles -> SSEG_AN=FF, SSEG_CA=FF; first edge after release -> AN=FE, CA=C0.
REQ-023 data=32'h12345678, dp=0 held through the first frame -> second frame shows AN FE,FD,FB,...,7F each for 4 cycles with CA 80,F8,82,92,99,B0,A4,F9.
REQ-024 Change data to 32'hFFFFFFFF mid-frame -> remainder of the frame is unchanged; the next frame shows CA=8E on all digits.
REQ-025 dp=8'h04, data=0 -> digit 2 slot shows CA=40; other slots show C0.
REQ-026 With SSEG_BLANK_EN, data=32'h00000A05 -> digits 0..2 show 92,C0,88; slots 3..7 show AN=FF; data=0 -> only digit 0 is lit, with C0.
REQ-027 Assert rst during digit 5 -> next edge outputs are FF/FF; after release the scan resumes at digit 0 with cleared shadow.
